// File: rtl/rx_link_fault_sm_pkg.sv
// Shared types and constants for the receive-side link fault sequencer.
// Column classification lives here so every column step decodes a column the same way.
package rx_lf_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_COUNT = 2'd1,
        ST_FAULT = 2'd2
    } lf_state_t;

    typedef enum logic [1:0] {
        LF_OK     = 2'b00,
        LF_LOCAL  = 2'b01,
        LF_REMOTE = 2'b10
    } lf_code_t;

    typedef enum logic {
        TYPE_LOCAL  = 1'b0,
        TYPE_REMOTE = 1'b1
    } fault_type_t;

    localparam logic [7:0] SEQ_CTRL = 8'h9C;
    localparam logic [7:0] LF_CODE  = 8'h01;
    localparam logic [7:0] RF_CODE  = 8'h02;

    typedef struct packed {
        lf_state_t   state;
        fault_type_t last_type;
        logic [2:0]  seq_cnt;
        logic [6:0]  col_cnt;
        lf_code_t    link_fault;
    } lf_regs_t;

    typedef struct packed {
        logic        is_seq;
        fault_type_t kind;
    } col_class_t;

    localparam lf_regs_t LF_REGS_RESET = '{
        state:      ST_INIT,
        last_type:  TYPE_LOCAL,
        seq_cnt:    3'd0,
        col_cnt:    7'd0,
        link_fault: LF_OK
    };

    // Unknown lane3 codes fall through as fault-free columns.
    function automatic col_class_t classify_column(input logic [31:0] data,
                                                   input logic [3:0]  ctrl);
        col_class_t cls;
        cls.is_seq = 1'b0;
        cls.kind   = TYPE_LOCAL;
        if (ctrl == 4'b0001 && data[7:0] == SEQ_CTRL && data[23:8] == 16'h0000) begin
            if (data[31:24] == LF_CODE) begin
                cls.is_seq = 1'b1;
                cls.kind   = TYPE_LOCAL;
            end else if (data[31:24] == RF_CODE) begin
                cls.is_seq = 1'b1;
                cls.kind   = TYPE_REMOTE;
            end
        end
        return cls;
    endfunction

    function automatic lf_code_t type_to_code(input fault_type_t kind);
        return (kind == TYPE_REMOTE) ? LF_REMOTE : LF_LOCAL;
    endfunction

endpackage

// File: rtl/rx_link_fault_sm_if.sv
// Receive word, enable and fault-status signals of the link fault sequencer.
// The RX capture side is the master; the sequencer is the slave.
interface rx_link_fault_sm_if #(
    parameter int CNT_W = 16
) ();
    import rx_lf_pkg::*;

    logic [63:0]      rxd64;
    logic [7:0]       rxc8;
    logic             lfsm_en;
    lf_code_t         link_fault;
    logic             tx_send_rf;
    logic             tx_send_idle;
    logic [CNT_W-1:0] fault_cnt;

    modport master (
        output rxd64,
        output rxc8,
        output lfsm_en,
        input  link_fault,
        input  tx_send_rf,
        input  tx_send_idle,
        input  fault_cnt
    );

    modport slave (
        input  rxd64,
        input  rxc8,
        input  lfsm_en,
        output link_fault,
        output tx_send_rf,
        output tx_send_idle,
        output fault_cnt
    );

endinterface

// File: rtl/rx_link_fault_sm_col_step.sv
// Combinational link-fault state update for a single XGMII column.
// fault_entry flags a COUNT-to-FAULT transition taken by this column.
module rx_lf_col_step
    import rx_lf_pkg::*;
#(
    parameter int SEQ_THRESH = 4,
    parameter int COL_LIMIT  = 128
) (
    input  lf_regs_t    cur,
    input  logic [31:0] col_data,
    input  logic [3:0]  col_ctrl,
    output lf_regs_t    nxt,
    output logic        fault_entry
);

    localparam logic [2:0] SEQ_LAST = 3'(SEQ_THRESH);
    localparam logic [6:0] COL_LAST = 7'(COL_LIMIT - 1);

    col_class_t col_cls;
    logic [2:0] seq_inc;

    // col_cnt holds the fault-free columns already seen, so the column arriving
    // with col_cnt at COL_LAST is the one that completes the clearing window.
    always_comb begin
        nxt         = cur;
        fault_entry = 1'b0;
        col_cls     = classify_column(col_data, col_ctrl);
        seq_inc     = cur.seq_cnt + 3'd1;

        case (cur.state)
            ST_INIT: begin
                if (col_cls.is_seq) begin
                    nxt.state     = ST_COUNT;
                    nxt.last_type = col_cls.kind;
                    nxt.seq_cnt   = 3'd1;
                    nxt.col_cnt   = 7'd0;
                end
            end

            ST_COUNT: begin
                if (col_cls.is_seq && col_cls.kind == cur.last_type) begin
                    nxt.seq_cnt = seq_inc;
                    nxt.col_cnt = 7'd0;
                    if (seq_inc == SEQ_LAST) begin
                        nxt.state      = ST_FAULT;
                        nxt.link_fault = type_to_code(col_cls.kind);
                        fault_entry    = 1'b1;
                    end
                end else if (col_cls.is_seq) begin
                    nxt.last_type = col_cls.kind;
                    nxt.seq_cnt   = 3'd1;
                    nxt.col_cnt   = 7'd0;
                end else if (cur.col_cnt == COL_LAST) begin
                    nxt = LF_REGS_RESET;
                end else begin
                    nxt.col_cnt = cur.col_cnt + 7'd1;
                end
            end

            ST_FAULT: begin
                if (col_cls.is_seq && col_cls.kind == cur.last_type) begin
                    nxt.col_cnt = 7'd0;
                end else if (col_cls.is_seq) begin
                    // Leaving FAULT on a type change keeps the declared fault visible.
                    nxt.state     = ST_COUNT;
                    nxt.last_type = col_cls.kind;
                    nxt.seq_cnt   = 3'd1;
                    nxt.col_cnt   = 7'd0;
                end else if (cur.col_cnt == COL_LAST) begin
                    nxt = LF_REGS_RESET;
                end else begin
                    nxt.col_cnt = cur.col_cnt + 7'd1;
                end
            end

            default: begin
                nxt = LF_REGS_RESET;
            end
        endcase
    end

endmodule

// File: rtl/rx_link_fault_sm.sv
// Receive link fault sequencer: two columns per rxclk, fault status and TX responses.
// Column 0 is stepped first and column 1 sees its result; only the final state is registered.
module rx_link_fault_sm
    import rx_lf_pkg::*;
#(
    parameter int SEQ_THRESH = 4,
    parameter int COL_LIMIT  = 128,
    parameter int CNT_W      = 16
) (
    input logic               rxclk,
    input logic               reset_n,
    rx_link_fault_sm_if.slave lf_bus
);

    lf_regs_t         regs;
    lf_regs_t         col0_regs;
    lf_regs_t         col1_regs;
    lf_regs_t         regs_next;
    logic             entry0;
    logic             entry1;
    logic [1:0]       entries;
    logic [CNT_W:0]   cnt_sum;
    logic [CNT_W-1:0] fault_cnt;
    logic [CNT_W-1:0] fault_cnt_next;
    logic             send_rf;
    logic             send_rf_next;
    logic             send_idle;
    logic             send_idle_next;

    rx_lf_col_step #(
        .SEQ_THRESH (SEQ_THRESH),
        .COL_LIMIT  (COL_LIMIT)
    ) u_col0 (
        .cur         (regs),
        .col_data    (lf_bus.rxd64[31:0]),
        .col_ctrl    (lf_bus.rxc8[3:0]),
        .nxt         (col0_regs),
        .fault_entry (entry0)
    );

    rx_lf_col_step #(
        .SEQ_THRESH (SEQ_THRESH),
        .COL_LIMIT  (COL_LIMIT)
    ) u_col1 (
        .cur         (col0_regs),
        .col_data    (lf_bus.rxd64[63:32]),
        .col_ctrl    (lf_bus.rxc8[7:4]),
        .nxt         (col1_regs),
        .fault_entry (entry1)
    );

    // Disable parks the machine in INIT but leaves the fault history counter alone.
    always_comb begin
        regs_next      = col1_regs;
        fault_cnt_next = fault_cnt;
        entries        = {1'b0, entry0} + {1'b0, entry1};
        cnt_sum        = {1'b0, fault_cnt} + {{(CNT_W-1){1'b0}}, entries};

        if (!lf_bus.lfsm_en) begin
            regs_next = LF_REGS_RESET;
        end else if (cnt_sum[CNT_W]) begin
            fault_cnt_next = '1;
        end else begin
            fault_cnt_next = cnt_sum[CNT_W-1:0];
        end

        send_rf_next   = (regs_next.link_fault == LF_LOCAL);
        send_idle_next = (regs_next.link_fault == LF_REMOTE);
    end

    always_ff @(posedge rxclk or negedge reset_n) begin
        if (!reset_n) begin
            regs      <= LF_REGS_RESET;
            fault_cnt <= '0;
            send_rf   <= 1'b0;
            send_idle <= 1'b0;
        end else begin
            regs      <= regs_next;
            fault_cnt <= fault_cnt_next;
            send_rf   <= send_rf_next;
            send_idle <= send_idle_next;
        end
    end

    assign lf_bus.link_fault   = regs.link_fault;
    assign lf_bus.tx_send_rf   = send_rf;
    assign lf_bus.tx_send_idle = send_idle;
    assign lf_bus.fault_cnt    = fault_cnt;

    link_fault_legal: assert property (@(posedge rxclk) disable iff (!reset_n)
                                       regs.link_fault != 2'b11);

endmodule

// File: tb/tb_rx_link_fault_sm.sv
// Self-checking bench for rx_link_fault_sm: column-level reference model checked every cycle,
// plus directed scenarios with hand-computed status and fault_cnt values.
module tb_rx_link_fault_sm;

    localparam int          SEQ_THRESH = 4;
    localparam int          COL_LIMIT  = 128;
    localparam int          CNT_W      = 16;
    localparam logic [31:0] LOC        = 32'h0100_009C;
    localparam logic [31:0] REM        = 32'h0200_009C;
    localparam logic [31:0] BAD        = 32'h0300_009C;
    localparam logic [31:0] IDL        = 32'h0707_0707;
    localparam logic [3:0]  K_SEQ      = 4'b0001;
    localparam logic [3:0]  K_IDL      = 4'b1111;
    localparam logic [3:0]  K_NONE     = 4'b0000;

    logic rxclk;
    logic reset_n;
    bit   cmp_en = 1'b0;
    int   tests_run = 0;
    int   tests_failed = 0;

    // Model: phase 0 idle, 1 counting a run, 2 fault declared; m_lf holds the 2-bit status code.
    int m_phase, m_type, m_len, m_quiet, m_lf, m_cnt;

    rx_link_fault_sm_if #(.CNT_W(CNT_W)) lf_bus ();

    rx_link_fault_sm #(
        .SEQ_THRESH (SEQ_THRESH),
        .COL_LIMIT  (COL_LIMIT),
        .CNT_W      (CNT_W)
    ) dut (
        .rxclk   (rxclk),
        .reset_n (reset_n),
        .lf_bus  (lf_bus)
    );

    initial rxclk = 1'b0;
    always #5 rxclk = ~rxclk;

    task automatic modelClear();
        m_phase = 0;
        m_type  = 0;
        m_len   = 0;
        m_quiet = 0;
        m_lf    = 0;
    endtask

    task automatic modelColumn(input logic [31:0] d, input logic [3:0] k);
        int kind;
        kind = 0;
        if (k == 4'b0001 && d[7:0] == 8'h9C && d[15:8] == 8'h00 && d[23:16] == 8'h00 &&
            (d[31:24] == 8'h01 || d[31:24] == 8'h02))
            kind = int'(d[31:24]);
        if (kind != 0) begin
            m_quiet = 0;
            if (m_phase == 0 || kind != m_type) begin
                m_phase = 1;
                m_type  = kind;
                m_len   = 1;
            end else if (m_phase == 1) begin
                m_len = m_len + 1;
                if (m_len == SEQ_THRESH) begin
                    m_phase = 2;
                    m_lf    = kind;
                    if (m_cnt < (1 << CNT_W) - 1) m_cnt = m_cnt + 1;
                end
            end
        end else if (m_phase != 0) begin
            m_quiet = m_quiet + 1;
            if (m_quiet == COL_LIMIT) modelClear();
        end
    endtask

    always @(posedge rxclk or negedge reset_n) begin
        if (!reset_n) begin
            modelClear();
            m_cnt = 0;
        end else if (!lf_bus.lfsm_en) begin
            modelClear();
        end else begin
            modelColumn(lf_bus.rxd64[31:0],  lf_bus.rxc8[3:0]);
            modelColumn(lf_bus.rxd64[63:32], lf_bus.rxc8[7:4]);
        end
    end

    task automatic compareField(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge rxclk) begin
        if (cmp_en) begin
            compareField("cycle.status",
                         {lf_bus.link_fault, lf_bus.tx_send_rf, lf_bus.tx_send_idle},
                         {m_lf[1:0], m_lf == 1, m_lf == 2});
            compareField("cycle.fault_cnt", lf_bus.fault_cnt, m_cnt[CNT_W-1:0]);
        end
    end

    task automatic checkOutput(input string name, input int exp_lf, input int exp_cnt);
        logic [1:0] e;
        e = exp_lf[1:0];
        compareField({name, ".status"},
                     {lf_bus.link_fault, lf_bus.tx_send_rf, lf_bus.tx_send_idle},
                     {e, e == 2'b01, e == 2'b10});
        compareField({name, ".fault_cnt"}, lf_bus.fault_cnt, exp_cnt[31:0]);
    endtask

    // Entered on a falling edge; leaves on the falling edge where the last word is visible.
    task automatic applyStimulus(input logic [31:0] c0, input logic [3:0] k0,
                                 input logic [31:0] c1, input logic [3:0] k1, input int words);
        for (int w = 0; w < words; w++) begin
            lf_bus.rxd64 = {c1, c0};
            lf_bus.rxc8  = {k1, k0};
            @(negedge rxclk);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n        = 1'b1;
        lf_bus.lfsm_en = 1'b1;
        lf_bus.rxd64   = {IDL, IDL};
        lf_bus.rxc8    = 8'hFF;
        #2 reset_n = 1'b0;
        cmp_en = 1'b1;

        for (int i = 0; i < 4; i++) begin
            @(negedge rxclk);
            checkOutput("reset_hold", 0, 0);
            lf_bus.rxd64   = {$urandom, $urandom};
            lf_bus.rxc8    = 8'($urandom);
            lf_bus.lfsm_en = 1'($urandom);
        end
        lf_bus.lfsm_en = 1'b1;
        reset_n        = 1'b1;
        applyStimulus(IDL, K_IDL, IDL, K_IDL, 2);
        checkOutput("idle_after_reset", 0, 0);

        applyStimulus(BAD, K_SEQ, LOC, K_NONE, 5);
        checkOutput("non_fault_columns", 0, 0);

        applyStimulus(LOC, K_SEQ, IDL, K_IDL, 3);
        checkOutput("local_3", 0, 0);
        applyStimulus(LOC, K_SEQ, IDL, K_IDL, 1);
        checkOutput("local_4", 1, 1);

        applyStimulus(IDL, K_IDL, IDL, K_IDL, 63);
        checkOutput("clear_63", 1, 1);
        applyStimulus(IDL, K_IDL, IDL, K_IDL, 1);
        checkOutput("clear_64", 0, 1);

        applyStimulus(LOC, K_SEQ, IDL, K_IDL, 4);
        checkOutput("refault", 1, 2);
        applyStimulus(IDL, K_IDL, IDL, K_IDL, 39);
        applyStimulus(LOC, K_SEQ, IDL, K_IDL, 1);
        applyStimulus(IDL, K_IDL, IDL, K_IDL, 63);
        checkOutput("restart_63", 1, 2);
        applyStimulus(IDL, K_IDL, IDL, K_IDL, 1);
        checkOutput("restart_64", 0, 2);

        applyStimulus(REM, K_SEQ, REM, K_SEQ, 1);
        checkOutput("remote_pair_1", 0, 2);
        applyStimulus(REM, K_SEQ, REM, K_SEQ, 1);
        checkOutput("remote_pair_2", 2, 3);
        applyStimulus(IDL, K_IDL, IDL, K_IDL, 64);
        checkOutput("remote_clear", 0, 3);

        applyStimulus(LOC, K_SEQ, IDL, K_IDL, 3);
        applyStimulus(IDL, K_IDL, IDL, K_IDL, 64);
        applyStimulus(LOC, K_SEQ, IDL, K_IDL, 1);
        checkOutput("expiry_restart", 0, 3);
        applyStimulus(LOC, K_SEQ, IDL, K_IDL, 2);
        checkOutput("expiry_seq3", 0, 3);
        applyStimulus(LOC, K_SEQ, IDL, K_IDL, 1);
        checkOutput("expiry_seq4", 1, 4);
        applyStimulus(IDL, K_IDL, IDL, K_IDL, 64);
        checkOutput("expiry_clear", 0, 4);

        applyStimulus(LOC, K_SEQ, IDL, K_IDL, 3);
        applyStimulus(IDL, K_IDL, IDL, K_IDL, 63);
        applyStimulus(LOC, K_SEQ, IDL, K_IDL, 1);
        checkOutput("window_edge", 1, 5);
        applyStimulus(IDL, K_IDL, IDL, K_IDL, 64);
        checkOutput("window_edge_clear", 0, 5);

        applyStimulus(LOC, K_SEQ, IDL, K_IDL, 2);
        applyStimulus(REM, K_SEQ, IDL, K_IDL, 3);
        checkOutput("type_remote_3", 0, 5);
        applyStimulus(REM, K_SEQ, IDL, K_IDL, 1);
        checkOutput("type_remote_4", 2, 6);
        applyStimulus(LOC, K_SEQ, IDL, K_IDL, 1);
        checkOutput("fault_type_swap", 2, 6);
        applyStimulus(LOC, K_SEQ, IDL, K_IDL, 3);
        checkOutput("swap_back_local", 1, 7);
        applyStimulus(IDL, K_IDL, IDL, K_IDL, 64);
        checkOutput("swap_clear", 0, 7);

        applyStimulus(LOC, K_SEQ, IDL, K_IDL, 2);
        lf_bus.lfsm_en = 1'b0;
        applyStimulus(LOC, K_SEQ, IDL, K_IDL, 1);
        checkOutput("enable_low_count", 0, 7);
        lf_bus.lfsm_en = 1'b1;
        applyStimulus(LOC, K_SEQ, IDL, K_IDL, 3);
        checkOutput("enable_restart", 0, 7);
        applyStimulus(LOC, K_SEQ, IDL, K_IDL, 1);
        checkOutput("enable_fault", 1, 8);
        lf_bus.lfsm_en = 1'b0;
        applyStimulus(IDL, K_IDL, IDL, K_IDL, 1);
        checkOutput("enable_low_fault", 0, 8);
        lf_bus.lfsm_en = 1'b1;

        applyStimulus(LOC, K_SEQ, IDL, K_IDL, 4);
        checkOutput("pre_async_reset", 1, 9);
        #2 reset_n = 1'b0;
        #1 checkOutput("async_reset", 0, 0);
        @(negedge rxclk);
        reset_n = 1'b1;
        applyStimulus(IDL, K_IDL, IDL, K_IDL, 2);
        checkOutput("post_async_reset", 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/rx_link_fault_sm.md
# rx_link_fault_sm

Receive-side link fault sequencer for the 10G MAC. It watches the 64-bit/8-lane de-DDR'd XGMII receive stream, two columns per cycle, for Sequence ordered sets. It runs the IEEE 802.3ae clause 46 link-fault state machine and drives the fault status plus transmit-side fault responses. It sits directly downstream of the receive DDR capture stage and upstream of the receive engine and the transmit RS.

## Interface
- `SEQ_THRESH`, default 4: consecutive same-type fault sequences needed to declare a fault.
- `COL_LIMIT`, default 128: fault-free columns that clear a pending count or a declared fault.
- `CNT_W`, default 16: width of the fault-entry counter.
- `rxclk`, input, 1: receive clock, one 64-bit word (2 columns) per edge. This is the only clock.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `rxd64`, input, 64: lane k is `rxd64[8k+7:8k]`. Lanes 0-3 form column 0 (earlier); lanes 4-7 form column 1.
- `rxc8`, input, 8: control flag per lane, bit k belongs to lane k.
- `lfsm_en`, input, 1: state machine enable. Low forces INIT synchronously.
- `link_fault`, output, 2: 00 = OK, 01 = local fault, 10 = remote fault. Value 11 is never driven.
- `tx_send_rf`, output, 1: request to the TX RS to transmit remote-fault sequences. Equals (`link_fault` == 01).
- `tx_send_idle`, output, 1: request to the TX RS to suppress frames and send idle. Equals (`link_fault` == 10).
- `fault_cnt`, output, CNT_W: saturating count of INIT/COUNT → FAULT entries.

## Operation
- A column is a fault sequence when all of the following hold:
  - lane0 = 0x9C with control flag 1;
  - lanes 1-3 have control flags 0;
  - lanes 1 and 2 = 0x00;
  - lane3 = 0x01 (local fault) or 0x02 (remote fault).
- Any other column counts as fault-free, including lane3 values that are neither 0x01 nor 0x02.
- State registers:
  - `state` ∈ {INIT, COUNT, FAULT};
  - `last_type` (local/remote);
  - `seq_cnt`, 3 bits;
  - `col_cnt`, 7 bits;
  - `link_fault`.
- Each cycle applies the column step to column 0, then to column 1 using the updated values. Only the result after column 1 is registered.
- Column step in INIT:
  - fault sequence: `last_type` ← type, `seq_cnt` ← 1, `col_cnt` ← 0, go to COUNT;
  - otherwise stay in INIT.
- Column step in COUNT:
  - fault sequence of the same type: `seq_cnt`+1, `col_cnt` ← 0; if `seq_cnt` reaches SEQ_THRESH, set `link_fault` ← type, go to FAULT, and increment `fault_cnt`;
  - fault sequence of a different type: `last_type` ← type, `seq_cnt` ← 1, `col_cnt` ← 0;
  - fault-free column: `col_cnt`+1; if `col_cnt` reaches COL_LIMIT−1, go to INIT and clear the counters.
- Column step in FAULT:
  - fault sequence of the same type: `col_cnt` ← 0;
  - fault sequence of a different type: `last_type` ← type, `seq_cnt` ← 1, `col_cnt` ← 0, go to COUNT; `link_fault` keeps its old value;
  - fault-free column: `col_cnt`+1; if `col_cnt` reaches COL_LIMIT−1, set `link_fault` ← 00 and go to INIT.
- A return to INIT from COUNT also clears `link_fault` to 00.
- When `lfsm_en` = 0, the next edge loads INIT with all counters 0 and `link_fault` = 00. `fault_cnt` is unaffected.
- `fault_cnt` saturates at all-ones. It is cleared only by reset.

## Timing
- Reset values: `state` INIT; all counters 0; `link_fault` 00; `tx_send_rf` 0; `tx_send_idle` 0; `fault_cnt` 0.
- Latency: one cycle. The outputs reflect the input word sampled on the previous `rxclk` edge.
- Two qualifying sequences in one word both count. Example: COUNT with `seq_cnt`=2 plus a word carrying two same-type sequences gives FAULT on the next edge.
- A fault entry and a same-word clear cannot both happen: column order decides the outcome.
- Asserting `reset_n` mid-count discards the partial count immediately, without waiting for a clock edge.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Package `rx_lf_pkg` holds:
  - the state enum;
  - the `link_fault` codes OK, LOCAL, REMOTE;
  - constants SEQ_CTRL = 0x9C, LF_CODE = 0x01, RF_CODE = 0x02.
- Sub-module `rx_lf_col_step` is a combinational single-column next-state function. The top level instantiates it twice in series.

## Test plan
- Reset: hold `reset_n` low with random inputs → `link_fault`=00, `tx_send_rf`=0, `tx_send_idle`=0, `fault_cnt`=0.
- Local fault: column 0 = {9C/K, 00, 00, 01} for 4 consecutive words, column 1 idle → `link_fault`=01 and `tx_send_rf`=1 one cycle after the 4th word; `fault_cnt`=1.
- Remote fault, two per word: both columns carry remote fault for 2 words → `link_fault`=10 and `tx_send_idle`=1 after the 2nd word.
- Expiry: 3 local sequences, then 64 idle words (128 columns), then 1 local sequence → `link_fault` stays 00, state is COUNT with `seq_cnt`=1.
- Fault clear: in local FAULT, 63 idle words → `link_fault` still 01; the 64th idle word → 00 the next cycle. A local sequence at word 40 restarts the 128-column window.
- Type change and enable:
  - 2 local then 4 remote sequences → `link_fault`=10 after the 4th remote;
  - dropping `lfsm_en` during COUNT → INIT next cycle, with `fault_cnt` unchanged.
